// File: rtl/crossy_pkg.sv
// Shared definitions for the crossy-road game: flow-state encodings, screen/frame
// constants used by the sequencer and the scroller, and the speed-level helper.
package crossy_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam int SCREEN_HEIGHT = 480;
  localparam int FRAME_CNT_W   = 6;   // frame counters cover HIT/flash spans up to 63 frames

  // Speed level is the score in whole steps, capped at the fastest level 7.
  function automatic logic [2:0] speed_of(input logic [6:0] score, input int step);
    int lvl;
    lvl = int'(score) / step;
    return (lvl > 7) ? 3'd7 : 3'(lvl);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchronizer, stability counter that flips the debounced
// level, and a one-cycle press pulse coincident with the level's rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses <= so all flops sample the pre-edge values; blocking
  // assignments would let sync2 see this cycle's sync1 and collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/PLAY/HIT/OVER flow, lives, hit flash timing, scroller control
// and registered speed level derived from the score.
module game_flow_ctrl
  import crossy_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int LIVES_INIT   = 3,
  parameter int HIT_FRAMES   = 60,
  parameter int FLASH_FRAMES = 8,
  parameter int LEVEL_STEP   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       collision,
  input  logic       frame_start,
  input  logic [6:0] score,
  output logic       scroll_move,
  output logic       scroll_reset,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [2:0] speed_level,
  output logic       flash
);

  logic btn_level;
  logic press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .level  (btn_level),
    .press  (press)
  );

  logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_next;
  logic [FRAME_CNT_W-1:0] flash_cnt, flash_cnt_next;
  logic [1:0]             state_next;
  logic [1:0]             lives_next;
  logic                   flash_next;

  // NOTE: each next-value is defaulted to its current register first, so no path through
  // the case statement leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    lives_next     = lives;
    frame_cnt_next = frame_cnt;
    flash_cnt_next = flash_cnt;
    flash_next     = flash;
    case (state)
      ST_IDLE: begin
        if (press) begin
          state_next = ST_PLAY;
          lives_next = 2'(LIVES_INIT);
        end
      end
      ST_PLAY: begin
        // A press in PLAY has no effect, so a coincident collision always wins.
        if (collision) begin
          state_next     = ST_HIT;
          lives_next     = lives - 2'd1;
          frame_cnt_next = '0;
          flash_cnt_next = '0;
          flash_next     = 1'b1;
        end
      end
      ST_HIT: begin
        if (frame_start) begin
          if (frame_cnt == FRAME_CNT_W'(HIT_FRAMES - 1)) begin
            state_next     = (lives == 2'd0) ? ST_OVER : ST_PLAY;
            frame_cnt_next = '0;
            flash_cnt_next = '0;
            flash_next     = 1'b0;
          end else begin
            frame_cnt_next = frame_cnt + FRAME_CNT_W'(1);
            if (flash_cnt == FRAME_CNT_W'(FLASH_FRAMES - 1)) begin
              flash_cnt_next = '0;
              flash_next     = ~flash;
            end else begin
              flash_cnt_next = flash_cnt + FRAME_CNT_W'(1);
            end
          end
        end
      end
      ST_OVER: begin
        if (press) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Scroller controls are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      lives        <= 2'(LIVES_INIT);
      frame_cnt    <= '0;
      flash_cnt    <= '0;
      flash        <= 1'b0;
      scroll_reset <= 1'b1;
      scroll_move  <= 1'b0;
      speed_level  <= 3'd0;
    end else begin
      state        <= state_next;
      lives        <= lives_next;
      frame_cnt    <= frame_cnt_next;
      flash_cnt    <= flash_cnt_next;
      flash        <= flash_next;
      scroll_reset <= (state_next == ST_IDLE);
      scroll_move  <= (state_next == ST_PLAY) && btn_level;
      speed_level  <= speed_of(score, LEVEL_STEP);
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: cycle-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_game_flow_ctrl;

  localparam int DEB  = 4;
  localparam int HITF = 3;
  localparam int FLF  = 1;
  localparam int LIV  = 2;
  localparam int STEP = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       collision;
  logic       frame_start;
  logic [6:0] score;
  logic       scroll_move;
  logic       scroll_reset;
  logic [1:0] state;
  logic [1:0] lives;
  logic [2:0] speed_level;
  logic       flash;

  game_flow_ctrl #(
    .DEBOUNCE_CYC(DEB), .LIVES_INIT(LIV), .HIT_FRAMES(HITF),
    .FLASH_FRAMES(FLF), .LEVEL_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .collision(collision),
    .frame_start(frame_start), .score(score), .scroll_move(scroll_move),
    .scroll_reset(scroll_reset), .state(state), .lives(lives),
    .speed_level(speed_level), .flash(flash)
  );

  always #20 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game flow from the rules, button from "raw value seen through two
  // flops must differ from the level for DEB consecutive cycles".
  int m_state, m_lives, m_hitn, m_speed, m_run;
  bit m_flash, m_move, m_sreset, m_level, m_press, m_s1, m_s2, m_ok;

  always @(posedge clk) begin
    bit new_press;
    if (reset) begin
      m_state = 0; m_lives = LIV; m_hitn = 0; m_speed = 0; m_run = 0;
      m_flash = 0; m_move = 0; m_sreset = 1; m_level = 0; m_press = 0;
      m_s1 = 0; m_s2 = 0; m_ok = 1;
    end else begin
      case (m_state)
        0: if (m_press) begin m_state = 1; m_lives = LIV; end
        1: if (collision) begin m_state = 2; m_lives = m_lives - 1; m_hitn = 0; end
        2: if (frame_start) begin
             m_hitn++;
             if (m_hitn == HITF) m_state = (m_lives == 0) ? 3 : 1;
           end
        default: if (m_press) m_state = 0;
      endcase
      m_flash  = (m_state == 2) && ((m_hitn / FLF) % 2 == 0);
      m_move   = (m_state == 1) && m_level;
      m_sreset = (m_state == 0);
      m_speed  = (int'(score) / STEP > 7) ? 7 : int'(score) / STEP;
      new_press = 0;
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = m_s2; new_press = m_s2; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_press = new_press;
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      n_vec++;
      if (state !== 2'(m_state) || lives !== 2'(m_lives) || scroll_move !== m_move ||
          scroll_reset !== m_sreset || speed_level !== 3'(m_speed) || flash !== m_flash) begin
        n_err++;
        $display("FAIL model t=%0t: got st=%0d lv=%0d mv=%0d rs=%0d sp=%0d fl=%0d, expected st=%0d lv=%0d mv=%0d rs=%0d sp=%0d fl=%0d",
                 $time, state, lives, scroll_move, scroll_reset, speed_level, flash,
                 m_state, m_lives, m_move, m_sreset, m_speed, m_flash);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; cyc(1); frame_start = 1'b0; cyc(1);
  endtask

  task automatic hold_press(input int n);
    btn_raw = 1'b1; cyc(n); btn_raw = 1'b0; cyc(10);
  endtask

  int lvl_score [7] = '{0, 9, 10, 35, 69, 70, 99};
  int lvl_exp   [7] = '{0, 0, 1, 3, 6, 7, 7};

  initial begin
    int waited;
    reset = 1'b1; btn_raw = 1'b0; collision = 1'b0; frame_start = 1'b0; score = 7'd0;
    cyc(3);
    check("reset_state", state, 0);
    check("reset_lives", lives, 2);
    check("reset_sreset", scroll_reset, 1);
    check("reset_flash", flash, 0);
    reset = 1'b0;

    // 1: short glitch must not register
    btn_raw = 1'b1; cyc(2); btn_raw = 1'b0; cyc(10);
    check("glitch_state", state, 0);
    check("glitch_sreset", scroll_reset, 1);

    // 2: held press starts the game; movement follows the held button
    btn_raw = 1'b1; cyc(8);
    check("press_state", state, 1);
    check("press_lives", lives, 2);
    check("press_move", scroll_move, 1);
    check("press_sreset", scroll_reset, 0);
    btn_raw = 1'b0;
    waited = 0;
    while (scroll_move !== 1'b0 && waited < 12) begin cyc(1); waited++; end
    check("move_drop_cycles_le7", int'(waited <= DEB + 3), 1);
    cyc(4);

    // 3: first hit, flash toggles per frame, collisions in HIT ignored
    collision = 1'b1; cyc(1); collision = 1'b0;
    check("hit1_state", state, 2);
    check("hit1_lives", lives, 1);
    check("hit1_move", scroll_move, 0);
    check("hit1_flash", flash, 1);
    collision = 1'b1; cyc(1); collision = 1'b0;
    check("hit1_ignore_coll", lives, 1);
    pulse_frame();
    check("flash_f1", flash, 0);
    pulse_frame();
    check("flash_f2", flash, 1);
    pulse_frame();
    check("hit1_exit_state", state, 1);
    check("hit1_exit_flash", flash, 0);

    // 4: last hit ends in OVER; press returns to IDLE, next press starts over
    collision = 1'b1; cyc(1); collision = 1'b0;
    check("hit2_lives", lives, 0);
    repeat (3) pulse_frame();
    check("over_state", state, 3);
    check("over_sreset", scroll_reset, 0);
    btn_raw = 1'b1; cyc(12);
    check("over_to_idle_held", state, 0);
    check("idle_sreset", scroll_reset, 1);
    btn_raw = 1'b0; cyc(10);
    hold_press(8);
    check("replay_state", state, 1);
    check("replay_lives", lives, 2);

    // 5: speed level sweep
    for (int i = 0; i < 7; i++) begin
      score = 7'(lvl_score[i]);
      cyc(1);
      check($sformatf("speed_%0d", lvl_score[i]), speed_level, lvl_exp[i]);
    end
    score = 7'd0; cyc(1);

    // 6: collision coincident with a press, then reset mid-HIT
    btn_raw = 1'b1; cyc(6);
    collision = 1'b1; cyc(1); collision = 1'b0;
    check("coll_press_state", state, 2);
    check("coll_press_lives", lives, 1);
    cyc(1);
    reset = 1'b1; btn_raw = 1'b0; cyc(1);
    check("midhit_reset_state", state, 0);
    check("midhit_reset_lives", lives, 2);
    check("midhit_reset_flash", flash, 0);
    reset = 1'b0; cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
